// File: rtl/ex_stage_if.sv
// ID/EX -> EX/MEM bundle for the execute stage, including the MEM/WB forwarding taps.
// The slave modport is the execute stage itself; the master modport is whatever drives it.
interface ex_stage_if #(
    parameter int XLEN = 32
);
    // ID/EX pipeline register contents
    logic            RegWrite_i;
    logic            MemtoReg_i;
    logic            MemRead_i;
    logic            MemWrite_i;
    logic [1:0]      ALUOp_i;
    logic            ALUSrc_i;
    logic [XLEN-1:0] data1_i;
    logic [XLEN-1:0] data2_i;
    logic [XLEN-1:0] ImmGen_i;
    logic [9:0]      funct_i;
    logic [4:0]      rs1_i;
    logic [4:0]      rs2_i;
    logic [4:0]      rd_i;

    // MEM/WB forwarding path
    logic            WB_RegWrite_i;
    logic [4:0]      WB_rd_i;
    logic [XLEN-1:0] WB_data_i;

    // EX/MEM pipeline register and the upstream hold request
    logic            RegWrite_o;
    logic            MemtoReg_o;
    logic            MemRead_o;
    logic            MemWrite_o;
    logic [XLEN-1:0] ALUResult_o;
    logic [XLEN-1:0] MemData_o;
    logic [4:0]      rd_o;
    logic            stall_o;

    modport slave (
        input  RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i,
        input  ALUOp_i, ALUSrc_i, data1_i, data2_i, ImmGen_i, funct_i,
        input  rs1_i, rs2_i, rd_i,
        input  WB_RegWrite_i, WB_rd_i, WB_data_i,
        output RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o,
        output ALUResult_o, MemData_o, rd_o, stall_o
    );

    modport master (
        output RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i,
        output ALUOp_i, ALUSrc_i, data1_i, data2_i, ImmGen_i, funct_i,
        output rs1_i, rs2_i, rd_i,
        output WB_RegWrite_i, WB_rd_i, WB_data_i,
        input  RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o,
        input  ALUResult_o, MemData_o, rd_o, stall_o
    );
endinterface

// File: rtl/ex_stage.sv
// Execute stage with EX/MEM register: operand forwarding, single-cycle ALU and an
// iterative shift-add multiplier that stalls the upstream pipe while it runs.
module ex_stage #(
    parameter int XLEN     = 32,
    parameter int MUL_STEP = 1
) (
    input  logic     clk_i,
    input  logic     rst_i,
    ex_stage_if.slave ex
);
    localparam int MUL_CYC = XLEN / MUL_STEP;
    localparam int CW      = $clog2(MUL_CYC + 1);
    localparam int SHW     = $clog2(XLEN);

    localparam logic [9:0] F_ADD = 10'b0000000_000;
    localparam logic [9:0] F_SUB = 10'b0100000_000;
    localparam logic [9:0] F_AND = 10'b0000000_111;
    localparam logic [9:0] F_XOR = 10'b0000000_100;
    localparam logic [9:0] F_SLL = 10'b0000000_001;
    localparam logic [9:0] F_MUL = 10'b0000001_000;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t          state_reg;
    logic [CW-1:0]   cnt_reg;
    logic [XLEN-1:0] mul_a_reg;
    logic [XLEN-1:0] mul_b_reg;
    logic [XLEN-1:0] acc_reg;

    logic            regwrite_reg;
    logic            memtoreg_reg;
    logic            memread_reg;
    logic            memwrite_reg;
    logic [XLEN-1:0] result_reg;
    logic [XLEN-1:0] memdata_reg;
    logic [4:0]      rd_reg;

    logic [XLEN-1:0] fwd_a;
    logic [XLEN-1:0] fwd_b;
    logic [XLEN-1:0] op_b;
    logic [XLEN-1:0] alu_result;
    logic [XLEN-1:0] step_sum;
    logic [XLEN-1:0] pp [MUL_STEP];
    logic            is_mul;
    logic            stall;

    // EX/MEM wins over MEM/WB because it holds the younger instruction's result
    always_comb begin
        fwd_a = ex.data1_i;
        if (regwrite_reg && (rd_reg != 5'd0) && (rd_reg == ex.rs1_i)) begin
            fwd_a = result_reg;
        end else if (ex.WB_RegWrite_i && (ex.WB_rd_i != 5'd0) && (ex.WB_rd_i == ex.rs1_i)) begin
            fwd_a = ex.WB_data_i;
        end
    end

    always_comb begin
        fwd_b = ex.data2_i;
        if (regwrite_reg && (rd_reg != 5'd0) && (rd_reg == ex.rs2_i)) begin
            fwd_b = result_reg;
        end else if (ex.WB_RegWrite_i && (ex.WB_rd_i != 5'd0) && (ex.WB_rd_i == ex.rs2_i)) begin
            fwd_b = ex.WB_data_i;
        end
    end

    assign op_b   = ex.ALUSrc_i ? ex.ImmGen_i : fwd_b;
    assign is_mul = (ex.ALUOp_i == 2'b10) && (ex.funct_i == F_MUL);

    always_comb begin
        alu_result = '0;
        unique case (ex.ALUOp_i)
            2'b00: alu_result = fwd_a + op_b;
            2'b01: alu_result = fwd_a - op_b;
            2'b10: begin
                case (ex.funct_i)
                    F_ADD:   alu_result = fwd_a + op_b;
                    F_SUB:   alu_result = fwd_a - op_b;
                    F_AND:   alu_result = fwd_a & op_b;
                    F_XOR:   alu_result = fwd_a ^ op_b;
                    F_SLL:   alu_result = fwd_a << op_b[SHW-1:0];
                    default: alu_result = '0;
                endcase
            end
            2'b11: begin
                case (ex.funct_i[2:0])
                    3'b000:  alu_result = fwd_a + op_b;
                    3'b101:  alu_result = $unsigned($signed(fwd_a) >>> ex.ImmGen_i[SHW-1:0]);
                    default: alu_result = '0;
                endcase
            end
            default: alu_result = '0;
        endcase
    end

    // Gated by rst_i so the hold request drops the instant reset is applied
    assign stall = rst_i && (((state_reg == S_IDLE) && is_mul) || (state_reg == S_BUSY));

    // One partial product per multiplier bit retired this cycle
    for (genvar gi = 0; gi < MUL_STEP; gi++) begin : g_pp
        assign pp[gi] = mul_b_reg[gi] ? (mul_a_reg << gi) : '0;
    end

    always_comb begin
        step_sum = '0;
        for (int k = 0; k < MUL_STEP; k++) begin
            step_sum = step_sum + pp[k];
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_reg <= S_IDLE;
            cnt_reg   <= '0;
            mul_a_reg <= '0;
            mul_b_reg <= '0;
            acc_reg   <= '0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (is_mul) begin
                        mul_a_reg <= fwd_a;
                        mul_b_reg <= op_b;
                        acc_reg   <= '0;
                        cnt_reg   <= CW'(MUL_CYC);
                        state_reg <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    acc_reg   <= acc_reg + step_sum;
                    mul_a_reg <= mul_a_reg << MUL_STEP;
                    mul_b_reg <= mul_b_reg >> MUL_STEP;
                    cnt_reg   <= cnt_reg - CW'(1);
                    if (cnt_reg == CW'(1)) begin
                        state_reg <= S_DONE;
                    end
                end
                S_DONE: begin
                    state_reg <= S_IDLE;
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            regwrite_reg <= 1'b0;
            memtoreg_reg <= 1'b0;
            memread_reg  <= 1'b0;
            memwrite_reg <= 1'b0;
            result_reg   <= '0;
            memdata_reg  <= '0;
            rd_reg       <= '0;
        end else if (stall) begin
            // Bubble so MEM/WB drain while the multiplier runs
            regwrite_reg <= 1'b0;
            memtoreg_reg <= 1'b0;
            memread_reg  <= 1'b0;
            memwrite_reg <= 1'b0;
            result_reg   <= '0;
            memdata_reg  <= '0;
            rd_reg       <= '0;
        end else begin
            regwrite_reg <= ex.RegWrite_i;
            memtoreg_reg <= ex.MemtoReg_i;
            memread_reg  <= ex.MemRead_i;
            memwrite_reg <= ex.MemWrite_i;
            result_reg   <= (state_reg == S_DONE) ? acc_reg : alu_result;
            memdata_reg  <= fwd_b;
            rd_reg       <= ex.rd_i;
        end
    end

    assign ex.RegWrite_o  = regwrite_reg;
    assign ex.MemtoReg_o  = memtoreg_reg;
    assign ex.MemRead_o   = memread_reg;
    assign ex.MemWrite_o  = memwrite_reg;
    assign ex.ALUResult_o = result_reg;
    assign ex.MemData_o   = memdata_reg;
    assign ex.rd_o        = rd_reg;
    assign ex.stall_o     = stall;
endmodule
